// File: rtl/mdu_param.sv
// mdu_param: parametrised HI/LO multiply/divide/accumulate unit with CP0 cancellation
module mdu_param #(
    parameter int WIDTH       = 32,
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [3:0]       op,
    input  logic             req,
    input  logic [WIDTH-1:0] rs,
    input  logic [WIDTH-1:0] rt,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    localparam int MAXC = MULT_CYCLES > DIV_CYCLES ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW   = $clog2(MAXC + 1);
    typedef enum logic {IDLE, RUN} state_t;
    state_t state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [3:0] op_q, op_n;
    logic [WIDTH-1:0] a, b, a_n, b_n, hi_n, lo_n;
    logic done_n, accept, in_div, sgn;
    logic [2*WIDTH-1:0] ax, bx, prod, acc, mres;
    logic a_neg, b_neg;
    logic [WIDTH-1:0] a_abs, b_abs, uq, ur, q, r;
    assign accept = start && !req && state == IDLE && op >= 4'd1 && op <= 4'd10;
    assign in_div = op_q == 4'd3 || op_q == 4'd4;
    assign sgn    = op_q == 4'd1 || op_q == 4'd3 || op_q == 4'd7 || op_q == 4'd9;
    // Sign-extend into 2*WIDTH so one unsigned multiplier serves both signednesses
    assign ax   = {{WIDTH{sgn & a[WIDTH-1]}}, a};
    assign bx   = {{WIDTH{sgn & b[WIDTH-1]}}, b};
    assign prod = ax * bx;
    assign acc  = {hi, lo};
    assign mres = (op_q == 4'd1 || op_q == 4'd2) ? prod :
                  (op_q == 4'd7 || op_q == 4'd8) ? acc + prod : acc - prod;
    // Divide magnitudes, then restore signs: quotient truncates, remainder follows dividend
    assign a_neg = sgn & a[WIDTH-1];
    assign b_neg = sgn & b[WIDTH-1];
    assign a_abs = a_neg ? -a : a;
    assign b_abs = b_neg ? -b : b;
    assign uq    = b_abs == '0 ? '0 : a_abs / b_abs;
    assign ur    = b_abs == '0 ? '0 : a_abs % b_abs;
    assign q     = (a_neg ^ b_neg) ? -uq : uq;
    assign r     = a_neg ? -ur : ur;
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        op_n    = op_q;
        a_n     = a;
        b_n     = b;
        hi_n    = hi;
        lo_n    = lo;
        done_n  = 1'b0;
        if (state == IDLE) begin
            if (accept && op == 4'd5) hi_n = rs;
            else if (accept && op == 4'd6) lo_n = rs;
            else if (accept) begin
                op_n    = op;
                a_n     = rs;
                b_n     = rt;
                cnt_n   = (op == 4'd3 || op == 4'd4) ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
                state_n = RUN;
            end
        end else if (req) begin
            state_n = IDLE;
            cnt_n   = '0;
        end else if (cnt == CW'(1)) begin
            state_n = IDLE;
            cnt_n   = '0;
            done_n  = 1'b1;
            if (!in_div) {hi_n, lo_n} = mres;
            else if (b != '0) begin
                hi_n = r;
                lo_n = q;
            end
        end else cnt_n = cnt - 1'b1;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
            op_q  <= '0;
            a     <= '0;
            b     <= '0;
            hi    <= '0;
            lo    <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            op_q  <= op_n;
            a     <= a_n;
            b     <= b_n;
            hi    <= hi_n;
            lo    <= lo_n;
            busy  <= state_n == RUN;
            done  <= done_n;
        end
    end
endmodule
